// File: rtl/fetch_queue_pkg.sv
// Pipeline-wide width defaults shared by all stages; the fetch queue takes its
// PC and instruction widths from here.
package fetch_queue_pkg;
    localparam int PCWidth  = 9;
    localparam int valWidth = 32;
endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: synchronous write, asynchronous read,
// synchronous clear while rst_n is low.
module fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 41
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: circular queue of {pc, instr}
// with valid/ready on both sides and a flush that empties it on redirect.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int PC_W    = PCWidth,
    parameter int INSTR_W = valWidth,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [INSTR_W-1:0]         in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [PC_W-1:0]            out_pc,
    output logic [INSTR_W-1:0]         out_instr,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = PC_W + INSTR_W;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;
    logic [ENT_W-1:0] head;

    // Handshakes depend only on registered occupancy, so in_ready never
    // combinationally follows out_ready.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (push && !flush),
        .waddr_i (wr_ptr_q),
        .wdata_i ({in_pc, in_instr}),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    assign out_pc    = out_valid ? head[ENT_W-1:INSTR_W] : '0;
    assign out_instr = out_valid ? head[INSTR_W-1:0]     : '0;
    assign count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a queue reference model is updated at each
// rising edge and a negedge monitor compares every DUT output against it.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [8:0]  in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        in_ready;
    logic        out_valid;
    logic [8:0]  out_pc;
    logic [31:0] out_instr;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    logic [40:0] mq[$];
    logic [8:0]  pop_log[$];

    fetch_queue #(.PC_W(9), .INSTR_W(32), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: acceptance decided from the model's own occupancy.
    always @(posedge clk) begin
        bit m_pop, m_push;
        if (!rst_n || flush) begin
            mq.delete();
        end else begin
            m_pop  = (mq.size() != 0) && out_ready;
            m_push = in_valid && (mq.size() != 4);
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back({in_pc, in_instr});
        end
    end

    // Monitor: compares against the scoreboard front whenever the DUT presents data.
    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_count", 32'(count), 32'(mq.size()));
            check("mon_in_ready", 32'(in_ready), 32'(mq.size() != 4));
            check("mon_out_valid", 32'(out_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                check("mon_out_pc", 32'(out_pc), 32'(mq[0][40:32]));
                check("mon_out_instr", out_instr, mq[0][31:0]);
            end else begin
                check("mon_out_pc_idle", 32'(out_pc), 32'h0);
                check("mon_out_instr_idle", out_instr, 32'h0);
            end
            if (out_valid && out_ready && rst_n && !flush) pop_log.push_back(out_pc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 32'(count), 32'h0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'h1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        check({tag, "_out_pc"}, 32'(out_pc), 32'h000);
        check({tag, "_out_instr"}, out_instr, 32'h0000_0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] exp_fill [5];
        exp_fill = '{9'h000, 9'h004, 9'h008, 9'h00C, 9'h010};

        // Reset held for two cycles
        step();
        mon_en = 1'b1;
        step();
        check_reset_state("reset");
        rst_n = 1'b1;

        // Fill to full with decode stalled
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_pc    = 9'(4 * i);
            in_instr = 32'h2008_0001 + 32'(i);
            step();
        end
        check("fill_count", 32'(count), 32'd4);
        check("fill_in_ready", 32'(in_ready), 32'h0);
        in_pc    = 9'h010;
        in_instr = 32'h2008_0005;
        step();
        check("full_hold_count", 32'(count), 32'd4);
        check("full_hold_head", 32'(out_pc), 32'h000);
        out_ready = 1'b1;
        step();
        check("full_pop_count", 32'(count), 32'd3);
        check("full_pop_in_ready", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        check("pushpop_count", 32'(count), 32'd3);
        repeat (3) step();
        out_ready = 1'b0;
        check("drain_count", 32'(count), 32'd0);
        check("drain_len", 32'(pop_log.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < pop_log.size()) check("drain_order", 32'(pop_log[i]), 32'(exp_fill[i]));
        end
        pop_log.delete();

        // Concurrent push and pop at count 2
        in_valid = 1'b1;
        in_pc = 9'h018; in_instr = 32'h2008_0018; step();
        in_pc = 9'h01C; in_instr = 32'h2008_001C; step();
        check("conc_pre_count", 32'(count), 32'd2);
        in_pc = 9'h020; in_instr = 32'h2008_0020; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("conc_count", 32'(count), 32'd2);
        check("conc_head1", 32'(out_pc), 32'h01C);
        step();
        check("conc_head2", 32'(out_pc), 32'h020);
        check("conc_head2_instr", out_instr, 32'h2008_0020);
        step();
        out_ready = 1'b0;
        check("conc_empty", 32'(out_valid), 32'h0);
        pop_log.delete();

        // Flush at count 3 with a same-cycle push
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_pc = 9'h030 + 9'(4 * i); in_instr = 32'hAC00_0030 + 32'(i); step();
        end
        check("flush_pre_count", 32'(count), 32'd3);
        in_pc = 9'h040; in_instr = 32'h2008_0040; flush = 1'b1;
        step();
        flush = 1'b0;
        in_pc = 9'h044; in_instr = 32'h2008_0044;
        check("flush_count", 32'(count), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'h0);
        check("flush_in_ready", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        check("post_flush_count", 32'(count), 32'd1);
        check("post_flush_pc", 32'(out_pc), 32'h044);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("post_flush_len", 32'(pop_log.size()), 32'd1);
        foreach (pop_log[i]) check("flush_no_0x040", 32'(pop_log[i] == 9'h040), 32'h0);
        pop_log.delete();

        // Wrap: ten-instruction stream at occupancy <= 1
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_pc    = 9'(4 * i);
            in_instr = 32'h2400_0000 + 32'(i);
            step();
            check("wrap_count", 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        check("wrap_len", 32'(pop_log.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < pop_log.size()) check("wrap_order", 32'(pop_log[i]), 32'(4 * i));
        end
        pop_log.delete();

        // Mid-operation reset at count 2
        in_valid = 1'b1;
        in_pc = 9'h050; in_instr = 32'h2008_0050; step();
        in_pc = 9'h054; in_instr = 32'h2008_0054; step();
        in_valid = 1'b0;
        check("midrst_pre_count", 32'(count), 32'd2);
        rst_n = 1'b0;
        step();
        check_reset_state("midrst");
        rst_n = 1'b1;
        in_valid = 1'b1; in_pc = 9'h060; in_instr = 32'h2008_0060;
        step();
        in_valid = 1'b0;
        check("midrst_push_pc", 32'(out_pc), 32'h060);
        check("midrst_push_instr", out_instr, 32'h2008_0060);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("midrst_pop_count", 32'(count), 32'd0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction buffer sitting directly downstream of fetch stage B and upstream of decode in the MIPS pipeline. It captures each fetched instruction together with the PC it was fetched from, and holds up to DEPTH entries so that decode stalls do not immediately stall the PC. It exposes valid/ready handshakes on both sides, and a flush input that discards all buffered instructions on a branch or jump redirect.

## Interface
- PC_W, default 9: PC / instruction-address width; matches the pipeline PC width.
- INSTR_W, default 32: instruction word width.
- DEPTH, default 4: number of entries; must be a power of two, ≥2.
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  fetch presents an instruction this cycle.
- in_pc  input  PC_W  PC of the presented instruction (the fetch address, not PC+4).
- in_instr  input  INSTR_W  instruction word read from instruction memory.
- in_ready  output  1  queue can accept a push this cycle; feeds PC-register stall.
- out_valid  output  1  head entry is valid for decode.
- out_pc  output  PC_W  PC of head entry.
- out_instr  output  INSTR_W  instruction of head entry.
- out_ready  input  1  decode consumes the head entry this cycle.
- flush  input  1  redirect: discard all entries, including any same-cycle push.
- count  output  clog2(DEPTH+1)  current occupancy.

## Operation
- Circular buffer: rd_ptr, wr_ptr (log2(DEPTH) bits each, wrap modulo DEPTH), plus count register.
- push = in_valid && in_ready; pop = out_valid && out_ready.
- in_ready = (count != DEPTH); derived from registered count only, never combinationally from out_ready.
- out_valid = (count != 0); out_pc and out_instr come from entry[rd_ptr] when valid, and are forced to 0 when out_valid = 0.
- push only: write entry[wr_ptr], wr_ptr+1, count+1.
- pop only: rd_ptr+1, count−1.
- push and pop together: both pointers advance, count unchanged, data order preserved.
- Full (count = DEPTH): in_ready = 0; an in_valid is not accepted even if out_ready = 1 in the same cycle. Fetch must hold its PC.
- Empty: out_valid = 0; out_ready is ignored, so pop never underflows.
- flush = 1 has priority over push and pop: rd_ptr, wr_ptr and count go to 0, and any same-cycle push is dropped. Entry contents need not be cleared.
- Reset (rst_n = 0 at a clock edge) behaves exactly as flush, regardless of current state. Entry contents are cleared to 0.

## Timing
- Reset values: count = 0, in_ready = 1, out_valid = 0, out_pc = 0, out_instr = 0.
- Latency: an instruction pushed at edge N appears on out_* in the cycle after edge N. There is no empty-queue fall-through bypass.
- Throughput: one push and one pop per cycle sustained whenever 0 < count < DEPTH.
- in_ready rises the cycle after the pop that leaves the queue non-full.
- After flush at edge N: out_valid = 0 and in_ready = 1 in cycle N+1, and a push is accepted at edge N+1.

## Structure
- PC_W and INSTR_W defaults come from the shared pipeline defines header (PCWidth, valWidth) used by all stages. Nothing queue-specific belongs there.
- One natural sub-module: fetch_queue_mem. It is a DEPTH×(PC_W+INSTR_W) register array with one synchronous write port, one asynchronous read port, and synchronous clear on reset.
- Pointer/count control stays in fetch_queue.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles -> count = 0, in_ready = 1, out_valid = 0, out_pc = 0x000, out_instr = 0x00000000.
- Fill/drain: with out_ready = 0, push pc 0x000/0x004/0x008/0x00C with instr 0x20080001..0x20080004 -> count = 4, in_ready = 0. A 5th push with pc 0x010 is held and not accepted. Then set out_ready = 1 -> the four entries emerge in order, one per cycle. Pc 0x010 is accepted the cycle after in_ready returns to 1.
- Concurrent: at count = 2, push pc 0x020 while popping -> count stays 2, and the next outputs are the old second entry, then 0x020.
- Flush: at count = 3, flush = 1 with in_valid = 1 (pc 0x040) -> next cycle count = 0, out_valid = 0. Pc 0x040 never appears on out_pc.
- Wrap: stream 10 instructions (pc 0x000..0x024) at count ≤ 1 -> pointers wrap twice, and out_pc sequence is exactly 0x000..0x024 with no loss or duplication.
- Mid-op reset: at count = 2, rst_n = 0 for 1 cycle -> same outputs as the reset scenario, and the next push/pop behave normally.
